alu_result_sel_pipe: RTL and testbench
======================================

Name: alu_result_sel_pipe

Overview:
- Parametrised, pipelined successor to the ALU main result selector.
- Takes one operand bus per ALU function unit (AND, OR, NOT, XOR, NAND, NOR, XNOR, ADD, SUB, SHRIGHT, SHLEFT, CLEAR) plus a one-hot opcode, and selects the result.
- Registers the result through a 2-stage valid/ready pipeline.
- Produces zero/negative/error flags and keeps a saturating count of illegal opcodes.
- Sits between the function units and the ALU output/writeback register.

Parameters:
- WIDTH, 16, data width of every operand and of the result.
- N_OPS, 12, number of function-unit inputs; sel width.
- CLEAR_IDX, 11, sel bit index that forces a zero result.
- ERR_CNT_W, 8, width of the illegal-opcode counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  opcode/operands valid.
- in_ready  output  1  stage 1 can accept.
- sel  input  N_OPS  one-hot opcode; bit i selects operand i.
- op_bus  input  N_OPS*WIDTH  flattened operands; operand i is op_bus[i*WIDTH +: WIDTH].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_res  output  WIDTH  selected result.
- out_idx  output  clog2(N_OPS)  index of the selected op; 0 on error.
- out_zero  output  1  out_res == 0.
- out_neg  output  1  out_res[WIDTH-1].
- out_err  output  1  sel was not one-hot.
- err_cnt  output  ERR_CNT_W  saturating count of accepted illegal opcodes.

Behaviour:
- **Reset**
  - Asynchronous; all state clears immediately.
  - out_valid=0, out_res=0, out_idx=0, out_zero=1, out_neg=0, out_err=0, err_cnt=0.
  - Stage-1 valid=0; in_ready=1 once reset deasserts.
  - Reset mid-transaction drops in-flight results without emitting them.
- **Accept**
  - A transfer occurs on the rising edge when in_valid && in_ready.
  - in_ready = !s1_valid || !out_valid || out_ready (combinational).
- **Stage 1 (decode/select), registered**
  - Exactly one sel bit set, at index i:
    - res = operand i;
    - idx = i;
    - err = 0;
    - if i == CLEAR_IDX, res = 0 regardless of operand.
  - sel == 0 or more than one bit set: res = 0, idx = 0, err = 1.
  - All decisions use the sampled sel. No latching on sel changes without a transfer.
- **Stage 2 (flags/output), registered**
  - Captures the stage-1 contents when !out_valid || out_ready.
  - out_zero and out_neg are computed from the stage-1 res and registered with it.
- **Latency and throughput**
  - Latency is exactly 2 clocks from the accepting edge to out_valid, with no stall.
  - Sustains 1 result per clock while out_ready=1.
- **Backpressure**
  - While out_valid && !out_ready, stage 2 holds all outputs stable.
  - Stage 1 holds one additional entry, so the pipeline holds 2 entries.
  - in_ready deasserts only when both stages are full and out_ready=0.
  - No data is lost or duplicated.
- **Simultaneous events**
  - Output pop and input push in the same cycle both complete.
  - The stage-1 entry moves to stage 2 and the new input fills stage 1.
- **err_cnt**
  - Increments on each accepted transfer whose sel is not one-hot.
  - Saturates at 2^ERR_CNT_W-1 with no wrap.
  - Cleared only by reset.
- **Flag timing**: outputs change only on clock edges.
- **Parameter checks**: WIDTH≥1; N_OPS≥2; CLEAR_IDX<N_OPS. Elaboration errors otherwise.

Decomposition:
- Shared package alu_pkg:
  - op index constants: OP_AND=0, OP_OR=1, OP_NOT=2, OP_XOR=3, OP_NAND=4, OP_NOR=5, OP_XNOR=6, OP_ADD=7, OP_SUB=8, OP_SHRIGHT=9, OP_SHLEFT=10, OP_CLEAR=11;
  - N_OPS_DEFAULT=12;
  - a function building the one-hot sel from an index.
- One sub-module, alu_onehot_decode: a combinational one-hot checker plus index encoder. It outputs idx and err and is reused by the opcode decoder.

Test Plan:
- Reset, then sel=opADD (bit 7), operand7=16'h1234, out_ready=1 -> two clocks later out_valid=1, out_res=16'h1234, out_idx=7, out_zero=0, out_neg=0, out_err=0.
- sel=opSUB, operand8=16'h8001 -> out_res=16'h8001, out_neg=1. Then sel=opCLEAR with operand11=16'hFFFF -> out_res=0, out_zero=1, out_err=0.
- sel=12'b000000000011, then sel=0 -> both out_err=1, out_res=0, out_idx=0, err_cnt=2. With ERR_CNT_W=2, 5 illegal opcodes -> err_cnt=3 (saturated).
- Back-to-back stream of 6 ops with out_ready held low for 4 cycles from cycle 3:
  - in_ready falls after 2 entries are held;
  - outputs stay stable;
  - all 6 results emerge in order, each exactly once.
- Continuous in_valid=1 and out_ready=1 for 10 ops -> one result per clock after a 2-cycle fill.
- Assert reset asynchronously (mid-cycle) with 2 entries in flight -> out_valid=0 and err_cnt=0 immediately; the flushed entries never appear.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function-unit operand slots and one-hot opcode helper.
// Slot order matches the physical order of the function-unit result buses.
package alu_pkg;

    localparam int OP_AND     = 0;
    localparam int OP_OR      = 1;
    localparam int OP_NOT     = 2;
    localparam int OP_XOR     = 3;
    localparam int OP_NAND    = 4;
    localparam int OP_NOR     = 5;
    localparam int OP_XNOR    = 6;
    localparam int OP_ADD     = 7;
    localparam int OP_SUB     = 8;
    localparam int OP_SHRIGHT = 9;
    localparam int OP_SHLEFT  = 10;
    localparam int OP_CLEAR   = 11;

    localparam int N_OPS_DEFAULT = 12;

    // Out-of-range index yields an all-zero (illegal) opcode.
    function automatic logic [N_OPS_DEFAULT-1:0] onehot_sel(input int unsigned idx);
        return N_OPS_DEFAULT'(1) << idx;
    endfunction

endpackage

// File: rtl/alu_result_sel_pipe_if.sv
// Opcode/operand request bus and flagged result bus of the ALU result selector.
// master drives requests and consumes results; slave is the selector pipeline.
interface alu_result_sel_pipe_if #(
    parameter int WIDTH     = 16,
    parameter int N_OPS     = 12,
    parameter int ERR_CNT_W = 8
);
    localparam int IDX_W = $clog2(N_OPS);

    logic                   in_valid;
    logic                   in_ready;
    logic [N_OPS-1:0]       sel;
    logic [N_OPS*WIDTH-1:0] op_bus;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_res;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_zero;
    logic                   out_neg;
    logic                   out_err;
    logic [ERR_CNT_W-1:0]   err_cnt;

    modport master (
        output in_valid, sel, op_bus, out_ready,
        input  in_ready, out_valid, out_res, out_idx, out_zero, out_neg, out_err, err_cnt
    );

    modport slave (
        input  in_valid, sel, op_bus, out_ready,
        output in_ready, out_valid, out_res, out_idx, out_zero, out_neg, out_err, err_cnt
    );

endinterface

// File: rtl/alu_onehot_decode.sv
// One-hot checker and index encoder for an opcode vector; purely combinational.
// err flags zero or multiple bits set, in which case idx is forced to 0.
module alu_onehot_decode #(
    parameter int N_OPS = 12,
    parameter int IDX_W = $clog2(N_OPS)
) (
    input  logic [N_OPS-1:0] sel,
    output logic [IDX_W-1:0] idx,
    output logic             err
);

    logic [IDX_W-1:0] idx_or;

    always_comb begin
        idx_or = '0;
        for (int i = 0; i < N_OPS; i++) begin
            if (sel[i]) begin
                idx_or = idx_or | IDX_W'(i);
            end
        end
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        err = (sel == '0) || ((sel & (sel - N_OPS'(1))) != '0);
        idx = err ? '0 : idx_or;
    end

endmodule

// File: rtl/alu_result_sel_pipe.sv
// ALU result selector: one-hot opcode picks an operand, result and flags leave after 2 clocks.
// Two-entry valid/ready pipeline; in_ready drops only when both stages are full and out_ready=0.
module alu_result_sel_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N_OPS     = N_OPS_DEFAULT,
    parameter int CLEAR_IDX = OP_CLEAR,
    parameter int ERR_CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    alu_result_sel_pipe_if.slave bus
);

    if (WIDTH < 1) begin : g_chk_width
        $error("alu_result_sel_pipe: WIDTH must be >= 1");
    end
    if (N_OPS < 2) begin : g_chk_nops
        $error("alu_result_sel_pipe: N_OPS must be >= 2");
    end
    if (CLEAR_IDX >= N_OPS || CLEAR_IDX < 0) begin : g_chk_clear
        $error("alu_result_sel_pipe: CLEAR_IDX must be < N_OPS");
    end

    localparam int IDX_W = $clog2(N_OPS);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [IDX_W-1:0] idx;
        logic             err;
    } ent_t;

    logic [IDX_W-1:0]     dec_idx;
    logic                 dec_err;
    ent_t                 dec_ent;
    ent_t                 s1;
    logic                 s1_valid;
    ent_t                 out_q;
    logic                 out_valid_q;
    logic                 out_zero_q;
    logic                 out_neg_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 s2_load;
    logic                 accept;

    alu_onehot_decode #(
        .N_OPS (N_OPS),
        .IDX_W (IDX_W)
    ) u_decode (
        .sel (bus.sel),
        .idx (dec_idx),
        .err (dec_err)
    );

    always_comb begin
        dec_ent.idx = dec_idx;
        dec_ent.err = dec_err;
        dec_ent.res = '0;
        if (!dec_err && (int'(dec_idx) != CLEAR_IDX)) begin
            dec_ent.res = bus.op_bus[int'(dec_idx)*WIDTH +: WIDTH];
        end
    end

    // Stage 2 can take a new entry whenever it is empty or being drained this cycle.
    assign s2_load      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1       <= dec_ent;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_zero_q  <= 1'b1;
            out_neg_q   <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_q      <= s1;
                out_zero_q <= (s1.res == '0);
                out_neg_q  <= s1.res[WIDTH-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (accept && dec_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_q.res;
    assign bus.out_idx   = out_q.idx;
    assign bus.out_err   = out_q.err;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_neg   = out_neg_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_result_sel_pipe.sv
// Directed bench for alu_result_sel_pipe: default instance plus a 2-bit error-counter instance.
module tb_alu_result_sel_pipe;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_result_sel_pipe_if #(.WIDTH(16), .N_OPS(12), .ERR_CNT_W(8)) b  ();
    alu_result_sel_pipe_if #(.WIDTH(16), .N_OPS(12), .ERR_CNT_W(2)) b2 ();

    alu_result_sel_pipe #(.WIDTH(16), .N_OPS(12), .CLEAR_IDX(11), .ERR_CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    alu_result_sel_pipe #(.WIDTH(16), .N_OPS(12), .CLEAR_IDX(11), .ERR_CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] v);
        b.op_bus[i*16 +: 16] = v;
    endtask

    task automatic test_reset();
        b.in_valid = 1'b0; b.sel = '0; b.op_bus = '0; b.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.sel = '0; b2.op_bus = '0; b2.out_ready = 1'b1;
        step();
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", b.out_valid); end
        checks++; if (b.out_res !== 16'h0000) begin errors++; $display("FAIL rst_out_res: got %h expected 0000", b.out_res); end
        checks++; if (b.out_idx !== 4'd0) begin errors++; $display("FAIL rst_out_idx: got %0d expected 0", b.out_idx); end
        checks++; if (b.out_zero !== 1'b1) begin errors++; $display("FAIL rst_out_zero: got %b expected 1", b.out_zero); end
        checks++; if (b.out_neg !== 1'b0) begin errors++; $display("FAIL rst_out_neg: got %b expected 0", b.out_neg); end
        checks++; if (b.out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err: got %b expected 0", b.out_err); end
        checks++; if (b.err_cnt !== 8'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d expected 0", b.err_cnt); end
        checks++; if (b2.err_cnt !== 2'd0) begin errors++; $display("FAIL rst_err_cnt_sat: got %0d expected 0", b2.err_cnt); end
        reset = 1'b0;
        #1;
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", b.in_ready); end
    endtask

    task automatic test_add();
        b.op_bus = {12{16'hDEAD}};
        set_op(OP_ADD, 16'h1234);
        b.sel = onehot_sel(OP_ADD);
        b.in_valid = 1'b1;
        b.out_ready = 1'b1;
        step();
        b.in_valid = 1'b0; b.sel = '0;
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL add_lat1_valid: got %b expected 0", b.out_valid); end
        step();
        checks++; if (b.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", b.out_valid); end
        checks++; if (b.out_res !== 16'h1234) begin errors++; $display("FAIL add_res: got %h expected 1234", b.out_res); end
        checks++; if (b.out_idx !== 4'd7) begin errors++; $display("FAIL add_idx: got %0d expected 7", b.out_idx); end
        checks++; if (b.out_zero !== 1'b0 || b.out_neg !== 1'b0 || b.out_err !== 1'b0) begin
            errors++; $display("FAIL add_flags: got z%b n%b e%b expected z0 n0 e0", b.out_zero, b.out_neg, b.out_err);
        end
        step();
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got %b expected 0", b.out_valid); end
    endtask

    task automatic test_sub_clear();
        b.op_bus = {12{16'h5A5A}};
        set_op(OP_SUB, 16'h8001);
        b.sel = onehot_sel(OP_SUB);
        b.in_valid = 1'b1;
        step();
        set_op(OP_CLEAR, 16'hFFFF);
        b.sel = onehot_sel(OP_CLEAR);
        step();
        b.in_valid = 1'b0; b.sel = '0;
        checks++; if (b.out_valid !== 1'b1 || b.out_res !== 16'h8001) begin
            errors++; $display("FAIL sub_res: got v%b %h expected v1 8001", b.out_valid, b.out_res);
        end
        checks++; if (b.out_neg !== 1'b1 || b.out_zero !== 1'b0 || b.out_idx !== 4'd8) begin
            errors++; $display("FAIL sub_flags: got n%b z%b idx%0d expected n1 z0 idx8", b.out_neg, b.out_zero, b.out_idx);
        end
        step();
        checks++; if (b.out_valid !== 1'b1 || b.out_res !== 16'h0000) begin
            errors++; $display("FAIL clear_res: got v%b %h expected v1 0000", b.out_valid, b.out_res);
        end
        checks++; if (b.out_zero !== 1'b1 || b.out_err !== 1'b0 || b.out_neg !== 1'b0 || b.out_idx !== 4'd11) begin
            errors++; $display("FAIL clear_flags: got z%b e%b n%b idx%0d expected z1 e0 n0 idx11", b.out_zero, b.out_err, b.out_neg, b.out_idx);
        end
        step();
    endtask

    task automatic test_illegal();
        b.op_bus = {12{16'h5555}};
        b.sel = 12'b0000_0000_0011;
        b.in_valid = 1'b1;
        step();
        b.sel = 12'b0000_0000_0000;
        step();
        b.in_valid = 1'b0;
        checks++; if (b.out_err !== 1'b1 || b.out_res !== 16'h0000 || b.out_idx !== 4'd0 || b.out_zero !== 1'b1) begin
            errors++; $display("FAIL illegal_multi: got e%b %h idx%0d z%b expected e1 0000 idx0 z1", b.out_err, b.out_res, b.out_idx, b.out_zero);
        end
        step();
        checks++; if (b.out_valid !== 1'b1 || b.out_err !== 1'b1 || b.out_res !== 16'h0000 || b.out_idx !== 4'd0) begin
            errors++; $display("FAIL illegal_zero: got v%b e%b %h idx%0d expected v1 e1 0000 idx0", b.out_valid, b.out_err, b.out_res, b.out_idx);
        end
        checks++; if (b.err_cnt !== 8'd2) begin errors++; $display("FAIL illegal_cnt: got %0d expected 2", b.err_cnt); end
        b2.sel = '0;
        b2.in_valid = 1'b1;
        repeat (3) step();
        checks++; if (b2.err_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt3: got %0d expected 3", b2.err_cnt); end
        repeat (2) step();
        b2.in_valid = 1'b0;
        checks++; if (b2.err_cnt !== 2'd3) begin errors++; $display("FAIL sat_nowrap: got %0d expected 3", b2.err_cnt); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        int occ  = 0;
        int cyc;
        logic held = 1'b0;
        logic [15:0] held_res = '0;
        logic stall_seen = 1'b0;
        logic acc, pop, exp_rdy;
        b.op_bus = '0;
        for (int t = 0; t < 40 && recv < 6; t++) begin
            cyc = t + 1;
            b.out_ready = !(cyc >= 3 && cyc <= 6);
            b.in_valid  = (sent < 6);
            b.sel       = (sent < 6) ? onehot_sel(sent) : '0;
            if (sent < 6) set_op(sent, 16'h0F00 + 16'(sent));
            #1;
            exp_rdy = (occ < 2) || b.out_ready;
            checks++; if (b.in_ready !== exp_rdy) begin
                errors++; $display("FAIL b2b_in_ready: cycle %0d got %b expected %b", cyc, b.in_ready, exp_rdy);
            end
            if (!b.in_ready) stall_seen = 1'b1;
            if (held) begin
                checks++; if (b.out_valid !== 1'b1 || b.out_res !== held_res) begin
                    errors++; $display("FAIL b2b_hold: cycle %0d got v%b %h expected v1 %h", cyc, b.out_valid, b.out_res, held_res);
                end
            end
            acc = b.in_valid && b.in_ready;
            pop = b.out_valid && b.out_ready;
            if (pop) begin
                checks++; if (b.out_res !== 16'h0F00 + 16'(recv) || b.out_idx !== 4'(recv)) begin
                    errors++; $display("FAIL b2b_order: got %h idx%0d expected %h idx%0d", b.out_res, b.out_idx, 16'h0F00 + 16'(recv), recv);
                end
            end
            held     = b.out_valid && !b.out_ready;
            held_res = b.out_res;
            step();
            if (acc) begin sent++; occ++; end
            if (pop) begin recv++; occ--; end
        end
        b.in_valid = 1'b0; b.sel = '0; b.out_ready = 1'b1;
        checks++; if (sent != 6 || recv != 6) begin errors++; $display("FAIL b2b_count: got sent %0d recv %0d expected 6 6", sent, recv); end
        checks++; if (!stall_seen) begin errors++; $display("FAIL b2b_stall: got no in_ready drop expected one"); end
        checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup: got out_valid %b expected 0", b.out_valid); end
    endtask

    task automatic test_throughput();
        b.out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t < 10) begin
                b.op_bus = '0;
                set_op(t, 16'h2000 + 16'(t) * 16'h0111);
                b.sel = onehot_sel(t);
                b.in_valid = 1'b1;
            end else begin
                b.in_valid = 1'b0;
                b.sel = '0;
            end
            step();
            if (t == 0 || t == 11) begin
                checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL tput_edge: step %0d got v%b expected v0", t, b.out_valid); end
            end else begin
                checks++; if (b.out_valid !== 1'b1 || b.out_res !== 16'h2000 + 16'(t-1) * 16'h0111 || b.out_idx !== 4'(t-1)) begin
                    errors++; $display("FAIL tput_stream: step %0d got v%b %h idx%0d expected v1 %h idx%0d",
                                       t, b.out_valid, b.out_res, b.out_idx, 16'h2000 + 16'(t-1) * 16'h0111, t-1);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        b.out_ready = 1'b0;
        b.op_bus = '0;
        set_op(OP_ADD, 16'h7777);
        b.sel = onehot_sel(OP_ADD);
        b.in_valid = 1'b1;
        step();
        b.sel = 12'b0000_0000_0101;
        step();
        b.in_valid = 1'b0; b.sel = '0;
        checks++; if (b.out_valid !== 1'b1 || b.err_cnt !== 8'd3 || b.in_ready !== 1'b0) begin
            errors++; $display("FAIL arst_prefill: got v%b cnt%0d rdy%b expected v1 cnt3 rdy0", b.out_valid, b.err_cnt, b.in_ready);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (b.out_valid !== 1'b0 || b.err_cnt !== 8'd0) begin
            errors++; $display("FAIL arst_immediate: got v%b cnt%0d expected v0 cnt0", b.out_valid, b.err_cnt);
        end
        #2;
        reset = 1'b0;
        b.out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            step();
            checks++; if (b.out_valid !== 1'b0) begin errors++; $display("FAIL arst_flush: step %0d got v%b expected v0", t, b.out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_clear();
        test_illegal();
        test_back_to_back();
        test_throughput();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
